riscv_alu_control: RTL and testbench
====================================

// Module: riscv_alu_control
// PURPOSE
//  ALU decoder for the RISC-V single-cycle/cache core datapath. It maps the
//  main decoder's ALUOp plus the instruction fields op[5], funct7[5] and
//  funct3 to the 3-bit ALUControl code that drives the ALU.
//  The output is registered on clk and can be configured as a combinational bypass.
// PARAMETERS
//  OUT_REG  default 1  1: outputs registered (1-cycle latency); 0: outputs combinational, clk/rst_n unused
// PORTS
//  clk         in   1  system clock, rising-edge active; single clock domain
//  rst_n       in   1  asynchronous, active-low reset
//  ALUOp       in   2  operation class from main decoder
//  op5         in   1  opcode bit 5 (1 = R-type, 0 = I-type ALU)
//  funct7      in   1  funct7 bit 5 of instruction
//  funct3      in   3  instruction funct3
//  ALUControl  out  3  ALU operation select
//  illegal_op  out  1  1 = unsupported ALUOp/funct3 combination decoded
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Decode table (next value, nxt_ctl):
//   - ALUOp=00 -> 000 (ADD: load/store address). funct3/op5/funct7 are ignored.
//   - ALUOp=01 -> 001 (SUB: branch compare). funct3/op5/funct7 are ignored.
//   - ALUOp=10 (R/I-type), by funct3:
//       000: {op5,funct7}=11 -> 001 (SUB); 00, 01 and 10 -> 000 (ADD/ADDI)
//       010 -> 101 (SLT)
//       110 -> 011 (OR)
//       111 -> 010 (AND)
//       other (001,011,100,101) -> 000, illegal_op=1
//   - ALUOp=11 -> 000, illegal_op=1
//  - illegal_op=0 for every case not listed above as illegal.
//  - X/Z on an ignored field must not propagate. Decode the ignored fields as
//    don't-care, e.g. with a case on ALUOp first.
//  OUT_REG=1 timing and reset:
//   - ALUControl/illegal_op update on every rising clk edge with the decode of the
//     inputs sampled at that edge. Latency is 1 cycle and there is no enable.
//   - While rst_n=0: ALUControl=000 and illegal_op=0, applied immediately and
//     asynchronously, with no clock needed.
//   - Reset asserted mid-operation clears outputs at once. The first edge after
//     rst_n rises loads the decode of the current inputs.
//   - Inputs that change between edges have no effect on the outputs until the next edge.
//  OUT_REG=0: outputs equal the current decode combinationally and ignore clk/rst_n.
//  No state machine; the only storage is the 4-bit output register.
// TESTING
//  (OUT_REG=1; "->" = value after next rising edge)
//  1. rst_n=0 with any inputs -> ALUControl=000, illegal_op=0 without a clock;
//     release rst_n, ALUOp=00 -> 000.
//  2. ALUOp=00 with funct3 held X -> 000, illegal_op=0; then ALUOp=01 -> 001.
//  3. ALUOp=10, funct3=000: {op5,funct7}=11 -> 001; then 10 -> 000; then 01 -> 000;
//     then 00 -> 000.
//  4. ALUOp=10, {op5,funct7}=10: funct3=010 -> 101; then 110 -> 011; then 111 -> 010;
//     illegal_op=0 throughout.
//  5. ALUOp=10, funct3=001/011/100/101 -> 000 with illegal_op=1; then ALUOp=11 -> 000
//     with illegal_op=1.
//  6. Toggle inputs between edges and confirm the outputs are unchanged until the edge.
//     Assert rst_n mid-stream and confirm the outputs clear immediately.

Source files
------------

// File: rtl/riscv_alu_control.sv
`default_nettype none
// ============================================================================
// Module      : riscv_alu_control
// Description : RISC-V ALU decoder; ALUOp/funct3/op5/funct7 -> ALUControl,
//               with optional registered output and illegal-op flag.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_alu_control #(
    parameter int OUT_REG = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] ALUOp,
    input  logic       op5,
    input  logic       funct7,
    input  logic [2:0] funct3,
    output logic [2:0] ALUControl,
    output logic       illegal_op
);

    localparam logic [2:0] C_ADD = 3'b000;
    localparam logic [2:0] C_SUB = 3'b001;
    localparam logic [2:0] C_AND = 3'b010;
    localparam logic [2:0] C_OR  = 3'b011;
    localparam logic [2:0] C_SLT = 3'b101;

    logic [2:0] w_nxt_ctl;
    logic       w_nxt_ill;

    // ALUOp is decoded first so funct fields never reach the output when ignored.
    always_comb begin
        w_nxt_ctl = C_ADD;
        w_nxt_ill = 1'b0;
        case (ALUOp)
            2'b00: w_nxt_ctl = C_ADD;
            2'b01: w_nxt_ctl = C_SUB;
            2'b10: begin
                case (funct3)
                    3'b000:  w_nxt_ctl = (op5 && funct7) ? C_SUB : C_ADD;
                    3'b010:  w_nxt_ctl = C_SLT;
                    3'b110:  w_nxt_ctl = C_OR;
                    3'b111:  w_nxt_ctl = C_AND;
                    default: w_nxt_ill = 1'b1;
                endcase
            end
            default: w_nxt_ill = 1'b1;
        endcase
    end

    generate
        if (OUT_REG != 0) begin : g_reg
            logic [2:0] r_ctl;
            logic       r_ill;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ctl <= C_ADD;
                    r_ill <= 1'b0;
                end else begin
                    r_ctl <= w_nxt_ctl;
                    r_ill <= w_nxt_ill;
                end
            end

            assign ALUControl = r_ctl;
            assign illegal_op = r_ill;
        end else begin : g_comb
            logic w_unused;
            assign w_unused   = &{1'b0, clk, rst_n};
            assign ALUControl = w_nxt_ctl;
            assign illegal_op = w_nxt_ill;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_riscv_alu_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_alu_control
// Description : Scoreboard bench for riscv_alu_control with OUT_REG=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_alu_control;

    typedef struct {
        string      name;
        logic [2:0] ctl;
        logic       ill;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] ALUOp;
    logic       op5;
    logic       funct7;
    logic [2:0] funct3;
    logic [2:0] ALUControl;
    logic       illegal_op;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    riscv_alu_control #(.OUT_REG(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ALUOp     (ALUOp),
        .op5       (op5),
        .funct7    (funct7),
        .funct3    (funct3),
        .ALUControl(ALUControl),
        .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [2:0] ec, input logic ei);
        n_cmp++;
        if ({ALUControl, illegal_op} !== {ec, ei}) begin
            n_err++;
            $display("FAIL %s: got ctl=%b ill=%b, expected ctl=%b ill=%b",
                     nm, ALUControl, illegal_op, ec, ei);
        end
    endtask

    // Applies inputs between edges; the expectation is for the following edge.
    task automatic drive(input string nm, input logic [1:0] a, input logic o5,
                         input logic f7, input logic [2:0] f3,
                         input logic [2:0] ec, input logic ei);
        exp_t e;
        @(negedge clk);
        ALUOp  = a;
        op5    = o5;
        funct7 = f7;
        funct3 = f3;
        e.name = nm;
        e.ctl  = ec;
        e.ill  = ei;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, e.ctl, e.ill);
        end
    end

    initial begin
        rst_n  = 1'b1;
        ALUOp  = 2'b10;
        op5    = 1'b1;
        funct7 = 1'b0;
        funct3 = 3'b010;
        #1 rst_n = 1'b0;
        #1 check("reset_no_clock", 3'b000, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        drive("release_add", 2'b00, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);

        drive("aluop00_fx",  2'b00, 1'b1, 1'b1, 3'bxxx, 3'b000, 1'b0);
        drive("aluop01_sub", 2'b01, 1'b1, 1'b1, 3'b110, 3'b001, 1'b0);

        drive("r_sub",       2'b10, 1'b1, 1'b1, 3'b000, 3'b001, 1'b0);
        drive("r_add",       2'b10, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
        drive("addi_f7",     2'b10, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0);
        drive("addi",        2'b10, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);

        drive("slt",         2'b10, 1'b1, 1'b0, 3'b010, 3'b101, 1'b0);
        drive("or",          2'b10, 1'b1, 1'b0, 3'b110, 3'b011, 1'b0);
        drive("and",         2'b10, 1'b1, 1'b0, 3'b111, 3'b010, 1'b0);

        drive("ill_f3_001",  2'b10, 1'b1, 1'b0, 3'b001, 3'b000, 1'b1);
        drive("ill_f3_011",  2'b10, 1'b1, 1'b0, 3'b011, 3'b000, 1'b1);
        drive("ill_f3_100",  2'b10, 1'b1, 1'b0, 3'b100, 3'b000, 1'b1);
        drive("ill_f3_101",  2'b10, 1'b0, 1'b1, 3'b101, 3'b000, 1'b1);
        drive("ill_aluop11", 2'b11, 1'b0, 1'b0, 3'b010, 3'b000, 1'b1);

        // Inputs moving between edges must not disturb the registered SLT result.
        drive("slt_again",   2'b10, 1'b1, 1'b0, 3'b010, 3'b101, 1'b0);
        drive("hold_edge",   2'b11, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
        #2 check("hold_between_1", 3'b101, 1'b0);
        funct3 = 3'b111;
        op5    = 1'b1;
        #1 check("hold_between_2", 3'b101, 1'b0);

        drive("pre_reset_or", 2'b10, 1'b1, 1'b0, 3'b110, 3'b011, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_clear", 3'b000, 1'b0);
        @(posedge clk);
        #2 check("reset_held", 3'b000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive("post_reset_and", 2'b10, 1'b0, 1'b0, 3'b111, 3'b010, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
